// File: rtl/tree_result_packer_if.sv
// tree_result_packer_if: valid/ready output stream carrying packed result words.
//   out_valid  head word present
//   out_ready  consumer accepts head when out_valid && out_ready
//   out_data   packed result bits, bit 0 oldest
//   out_count  meaningful bits in out_data
// master = producer (packer), slave = consumer.
interface tree_result_packer_if #(parameter int PACK_W = 8);
    localparam int CW = $clog2(PACK_W + 1);
    logic              out_valid;
    logic              out_ready;
    logic [PACK_W-1:0] out_data;
    logic [CW-1:0]     out_count;
    modport master (output out_valid, out_data, out_count, input out_ready);
    modport slave  (input out_valid, out_data, out_count, output out_ready);
endinterface

// File: rtl/tree_result_packer.sv
// tree_result_packer: packs valid reduction-tree result bits LSB-first into words behind a FIFO.
//   clk        clock
//   rst        synchronous active-high reset
//   src_valid  a real word enters the tree this cycle
//   tree_b     tree result bit, valid LATENCY cycles after src_valid
//   flush      emit the current partial word
//   overflow   sticky: a completed word was dropped on a full FIFO
//   bus        output stream (out_valid/out_ready/out_data/out_count)
module tree_result_packer #(
    parameter int LATENCY = 3,
    parameter int PACK_W  = 8,
    parameter int DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic src_valid,
    input  logic tree_b,
    input  logic flush,
    output logic overflow,
    tree_result_packer_if.master bus
);
    localparam int CW = $clog2(PACK_W + 1);
    localparam int AW = $clog2(DEPTH);
    logic [LATENCY-1:0] vsr;
    logic               res_valid, complete, push, pop, wr, full, empty;
    logic [CW-1:0]      fill, push_count;
    logic [PACK_W-1:0]  acc, push_data;
    logic [AW:0]        wp, rp;
    logic [PACK_W-1:0]  mem_data [DEPTH];
    logic [CW-1:0]      mem_count [DEPTH];
    always_comb begin
        res_valid  = vsr[LATENCY-1];
        complete   = res_valid && fill == CW'(PACK_W - 1);
        push       = complete || (flush && (fill != '0 || res_valid));
        // acc bits at and above fill are always zero, so OR-ing in the new bit is enough
        push_data  = acc | (PACK_W'(res_valid & tree_b) << fill);
        push_count = fill + CW'(res_valid);
        empty      = wp == rp;
        full       = wp == {~rp[AW], rp[AW-1:0]};
        pop        = !empty && bus.out_ready;
        wr         = push && (!full || pop);
    end
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem_data[rp[AW-1:0]];
    assign bus.out_count = empty ? '0 : mem_count[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            vsr      <= '0;
            fill     <= '0;
            acc      <= '0;
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            vsr  <= LATENCY'({vsr, src_valid});
            fill <= push ? '0 : push_count;
            acc  <= push ? '0 : push_data;
            if (wr) wp <= wp + (AW + 1)'(1);
            if (pop) rp <= rp + (AW + 1)'(1);
            if (push && !wr) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_data[wp[AW-1:0]]  <= push_data;
            mem_count[wp[AW-1:0]] <= push_count;
        end
    end
endmodule

// File: tb/tb_tree_result_packer.sv
// tb_tree_result_packer: directed table-driven bench for tree_result_packer with a LATENCY-deep tree model.
module tb_tree_result_packer;
    localparam int LAT = 3;
    typedef struct {
        logic [7:0]  bits;
        int          n;
        logic [15:0] gaps;
        logic        fl;
        logic [7:0]  ed;
        logic [3:0]  ec;
        int          lat;
    } vec_t;
    logic       clk = 1'b0, rst = 1'b1, src_valid = 1'b0, a_b = 1'b1, flush = 1'b0;
    logic       overflow, tree_b;
    logic [2:0] bpipe = '0;
    int         pass_cnt = 0, total = 0;
    tree_result_packer_if #(.PACK_W(8)) bus ();
    tree_result_packer #(.LATENCY(LAT), .PACK_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .tree_b(tree_b),
        .flush(flush), .overflow(overflow), .bus(bus)
    );
    always #5 clk = ~clk;
    // tree stand-in: unresettable pipeline of the result bit for each word on `a`
    always @(posedge clk) bpipe <= {bpipe[1:0], a_b};
    assign tree_b = bpipe[2];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    // one valid word whose tree result is b, then gap idle cycles with the tree output forced to 1
    task automatic push_res(input logic b, input int gap);
        src_valid = 1'b1;
        a_b = b;
        step();
        src_valid = 1'b0;
        a_b = 1'b1;
        repeat (gap) step();
    endtask
    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) push_res(w[i], 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        vec_t v[6];
        int   n;
        logic [7:0] w[5];
        v[0] = '{8'h4D, 8, 16'h0000, 1'b0, 8'h4D, 4'd8, 4};
        v[1] = '{8'h4D, 8, 16'hE4E4, 1'b0, 8'h4D, 4'd8, 4};
        v[2] = '{8'h07, 3, 16'h0000, 1'b1, 8'h07, 4'd3, 0};
        v[3] = '{8'hA5, 8, 16'h0000, 1'b0, 8'hA5, 4'd8, 4};
        v[4] = '{8'h01, 1, 16'h0000, 1'b1, 8'h01, 4'd1, 0};
        v[5] = '{8'h3C, 6, 16'h0926, 1'b1, 8'h3C, 4'd6, 0};
        bus.out_ready = 1'b1;
        repeat (2) step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_count", 32'(bus.out_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        step();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < v[r].n; i++)
                push_res(v[r].bits[i], (i < v[r].n - 1) ? int'(v[r].gaps[2*i +: 2]) : 0);
            if (v[r].fl) begin
                repeat (LAT) step();
                flush = 1'b1;
                step();
                flush = 1'b0;
            end
            n = 1;
            while (!bus.out_valid && n < 20) begin
                step();
                n++;
            end
            if (v[r].lat != 0) chk($sformatf("latency%0d", r), 32'(n), 32'(v[r].lat));
            chk($sformatf("valid%0d", r), 32'(bus.out_valid), 32'd1);
            chk($sformatf("data%0d", r), 32'(bus.out_data), 32'(v[r].ed));
            chk($sformatf("count%0d", r), 32'(bus.out_count), 32'(v[r].ec));
            step();
            chk($sformatf("drained%0d", r), 32'(bus.out_valid), 32'd0);
        end
        // flush with nothing accumulated
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("flush_noop", 32'(bus.out_valid), 32'd0);
        // flush landing on the completing result
        for (int i = 0; i < 8; i++) push_res(w_bit(8'h96, i), 0);
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_full_valid", 32'(bus.out_valid), 32'd1);
        chk("flush_full_data", 32'(bus.out_data), 32'h96);
        chk("flush_full_count", 32'(bus.out_count), 32'd8);
        step();
        chk("flush_full_single", 32'(bus.out_valid), 32'd0);
        // overflow: five words into a four-entry FIFO with no consumer
        for (int k = 0; k < 5; k++) w[k] = 8'(8'h11 * (k + 1));
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_word(w[k]);
        repeat (LAT) step();
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_data%0d", k), 32'(bus.out_data), 32'(w[k]));
            chk($sformatf("ovf_count%0d", k), 32'(bus.out_count), 32'd8);
            step();
        end
        chk("ovf_empty", 32'(bus.out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        // full FIFO, push and pop on the same edge
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clears_ovf", 32'(overflow), 32'd0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) w[k] = 8'(8'h61 + k);
        for (int k = 0; k < 5; k++) push_word(w[k]);
        repeat (2) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pp_overflow", 32'(overflow), 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("pp_data%0d", k), 32'(bus.out_data), 32'(w[k]));
            step();
        end
        chk("pp_empty", 32'(bus.out_valid), 32'd0);
        // reset with fill=5 and two results still in the tree
        for (int i = 0; i < 7; i++) push_res(1'b1, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();
        chk("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("mid_rst_fill_clear", 32'(bus.out_valid), 32'd0);
        push_word(8'hC3);
        repeat (LAT) step();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'hC3);
        chk("post_rst_count", 32'(bus.out_count), 32'd8);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
    function automatic logic w_bit(input logic [7:0] w, input int i);
        return w[i];
    endfunction
endmodule

// File: doc/tree_result_packer.md
Name: tree_result_packer

Overview:
- Sits directly downstream of the pipelined 16-bit reduction tree; consumes its 1-bit result `b`.
- The tree has no valid or handshake. This block tracks, through a matching delay line, which tree outputs correspond to real input words.
- It packs valid result bits LSB-first into PACK_W-bit words and buffers them in a small FIFO behind a valid/ready output port.
- Supports a flush of partial words and flags dropped words with a sticky overflow bit.

Parameters:
- LATENCY, 3: cycles from the word on tree `a` to the corresponding `b`; equals tree pipeline depth.
- PACK_W, 8: result bits per packed output word; must be >= 2.
- DEPTH, 4: output FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  1  high in the same cycle a valid word is driven onto the tree's `a` input.
- tree_b  in  1  the tree's `b` output.
- flush  in  1  one-cycle request to emit the current partial word.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- out_data  out  PACK_W  packed result bits; bit 0 is the oldest result.
- out_count  out  $clog2(PACK_W+1)  number of meaningful bits in out_data (1..PACK_W).
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_count=0, overflow=0. Reset also clears FIFO pointers, the fill counter, the accumulator and the whole valid delay line.
- Reset mid-operation: tree results already in flight are discarded, because the tree itself has no reset. The first result accepted after reset comes from a src_valid sampled after rst deasserts.
- Valid tracking:
  - res_valid is src_valid delayed by exactly LATENCY cycles (a LATENCY-deep shift register).
  - src_valid high in cycle t means tree_b is sampled in cycle t+LATENCY.
  - When res_valid is low, tree_b is ignored.
- Packing:
  - The fill counter runs 0..PACK_W-1.
  - On res_valid, tree_b is written to acc[fill] and fill increments.
  - When res_valid && fill==PACK_W-1, the word {tree_b, acc[PACK_W-2:0]} is pushed with count=PACK_W. Fill and acc return to 0 in the same edge.
- Flush:
  - Sampled every cycle.
  - If flush && (fill>0 || res_valid) and the word is not completing, push the partial word with count = fill + res_valid.
  - Unused upper bits of a flushed word are 0; fill and acc clear.
  - If flush coincides with a completing word, exactly one full word is pushed; no extra empty word.
  - flush with fill==0 and no res_valid is a no-op.
- FIFO:
  - DEPTH entries, each holding data plus count; pointers wrap modulo DEPTH, with an extra pointer bit or occupancy counter to distinguish full from empty.
  - out_valid = !empty.
  - out_data and out_count reflect the head when out_valid is high, and are 0 when it is low.
  - Pop happens when out_valid && out_ready.
  - A push is visible on out_valid no earlier than the cycle after the pushing edge. Latency from the last contributing tree_b sample to out_valid is 1 cycle when the FIFO is empty.
- Full-FIFO rules:
  - Push and pop in the same cycle when full: both occur, no drop, occupancy unchanged.
  - Push when full without a pop: the word is dropped, overflow is set to 1, and the FIFO contents are unchanged.
  - overflow clears only on rst.
- Order: words leave in push order; bit order within a word is arrival order, LSB first.
- Backpressure: out_ready low never stalls the tree or the valid delay line. The upstream stage cannot stall, so loss is signalled only via overflow.

Test Plan:
1. Eight back-to-back src_valid words on `a`, in the order 0101,FFFF,0101,0101,FFFF,FFFF,0101,FFFF (tree b = 1,0,1,1,0,0,1,0), with out_ready=1 -> one word out_data=0x4D, out_count=8. out_valid rises 1 cycle after the 8th result is sampled, i.e. LATENCY+1 cycles after the 8th src_valid.
2. Same eight words with src_valid gaps of 0-3 idle cycles, and tree_b forced to 1 during the idle gaps -> identical single output 0x4D/8; gap values are never captured.
3. Three results 1,1,1, then flush -> out_data=0x07, out_count=3. A second flush with no new results -> no new word. Flush coinciding with the 8th result -> exactly one word with count=8.
4. out_ready=0 and DEPTH+1=5 complete words pushed -> first 4 held, overflow=1 and stays 1. With out_ready=1 the 4 drain in order, then out_valid=0.
5. FIFO full, and in the same cycle a new word completes while out_ready=1 -> no drop, overflow stays 0, occupancy stays 4.
6. rst asserted for 1 cycle while 2 src_valid words are in flight and fill=5 -> after reset no output from the in-flight words. The next 8 valid results form a clean word with count=8.
